// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 host-side blocks (transmit
// path here, keyboard receive path elsewhere).
//   ps2_state_t        : host transmit FSM state encoding
//   DEF_*_CYCLES       : default timing constants for a 100 MHz system clock
//   odd_parity()       : PS/2 frame parity bit for a data byte
package ps2_pkg;

   // PS/2 clock held low before request-to-send (100 us at 100 MHz).
   localparam int DEF_INHIBIT_CYCLES = 10000;
   // Data held low together with clock before the clock is released.
   localparam int DEF_RTS_CYCLES     = 20;
   // Frame abort limit counted from clock release (20 ms at 100 MHz).
   localparam int DEF_TIMEOUT_CYCLES = 2000000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RTS       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_state_t;

   // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if -- command byte handshake between a requester and the
// PS/2 host transmitter.
//   tx_valid : request to send tx_data
//   tx_data  : command byte (e.g. 0xED set-LEDs, 0xF4 enable)
//   tx_ready : transmitter idle and able to accept a byte
//   tx_done  : one-cycle pulse, frame acknowledged and bus idle again
//   tx_err   : one-cycle pulse, missing ack or frame timeout
//
// Handshake: a byte is taken on a rising clk edge where tx_valid and
// tx_ready are both 1. tx_valid while tx_ready is 0 is dropped, not queued,
// and tx_data is free to change once the byte has been taken. Every taken
// byte ends in exactly one tx_done or tx_err pulse (unless reset intervenes).
interface ps2_host_tx_if;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_err;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready,
      input  tx_done,
      input  tx_err
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready,
      output tx_done,
      output tx_err
   );

endinterface

// File: rtl/ps2_sync.sv
// ps2_sync -- brings the asynchronous PS/2 clock and data pad levels into
// the system clock domain and flags device clock falling edges.
//   clk        : system clock
//   rst        : asynchronous active-low reset (flops go to the idle-high level)
//   ps2_clk_i  : PS2_CLK pad level
//   ps2_data_i : PS2_DATA pad level
//   clk_s      : synchronized PS/2 clock
//   data_s     : synchronized PS/2 data
//   clk_fall   : one-cycle pulse, synchronized clock went 1 -> 0
module ps2_sync (
   input  logic clk,
   input  logic rst,
   input  logic ps2_clk_i,
   input  logic ps2_data_i,
   output logic clk_s,
   output logic data_s,
   output logic clk_fall
);

   logic [1:0] clk_ff;
   logic [1:0] data_ff;
   logic       clk_prev;

   // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_ff   <= 2'b11;
         data_ff  <= 2'b11;
         clk_prev <= 1'b1;
      end else begin
         clk_ff   <= {clk_ff[0], ps2_clk_i};
         data_ff  <= {data_ff[0], ps2_data_i};
         clk_prev <= clk_ff[1];
      end
   end

   assign clk_s    = clk_ff[1];
   assign data_s   = data_ff[1];
   assign clk_fall = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- PS/2 host-to-device transmitter (sends one command byte).
//   clk         : system clock, single domain
//   rst         : asynchronous active-low reset
//   tx          : command handshake (slave side of ps2_host_tx_if)
//   ps2_clk_i   : PS2_CLK pad level (asynchronous)
//   ps2_data_i  : PS2_DATA pad level (asynchronous)
//   ps2_clk_oe  : 1 = pull PS2_CLK low, 0 = release (open drain)
//   ps2_data_oe : 1 = pull PS2_DATA low, 0 = release (open drain)
//   fsm_state   : current transmit FSM state, for observation
//
// Sequence: hold clock low (inhibit), pull data low as the start bit
// (request-to-send), release clock, then present one bit per device falling
// edge (8 data bits LSB first, odd parity, stop), then read the device ack.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int RTS_CYCLES     = DEF_RTS_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   ps2_host_tx_if.slave        tx,
   input  logic                ps2_clk_i,
   input  logic                ps2_data_i,
   output logic                ps2_clk_oe,
   output logic                ps2_data_oe,
   output ps2_state_t          fsm_state
);

   // One cycle counter serves inhibit, RTS and the frame timeout, so size it
   // for the largest of the three limits.
   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
                            ((TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES) :
                            ((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ps2_state_t       state_q, state_n;
   logic [CNT_W-1:0] cyc_q, cyc_n;
   logic [3:0]       bit_q, bit_n;
   logic [7:0]       byte_q, byte_n;
   logic             parity_q, parity_n;
   logic             data_oe_q, data_oe_n;
   logic             done_q, done_n;
   logic             err_q, err_n;

   logic             clk_s;
   logic             data_s;
   logic             clk_fall;
   logic             in_frame;

   ps2_sync u_sync (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_data_i (ps2_data_i),
      .clk_s      (clk_s),
      .data_s     (data_s),
      .clk_fall   (clk_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         cyc_q     <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         parity_q  <= 1'b0;
         data_oe_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_n;
         cyc_q     <= cyc_n;
         bit_q     <= bit_n;
         byte_q    <= byte_n;
         parity_q  <= parity_n;
         data_oe_q <= data_oe_n;
         done_q    <= done_n;
         err_q     <= err_n;
      end
   end

   // Once the clock is released, the device owns the timing; the timeout
   // guards everything from release until the bus goes idle again.
   assign in_frame = (state_q == ST_SEND) || (state_q == ST_ACK) ||
                     (state_q == ST_WAIT_IDLE);

   always_comb begin
      state_n   = state_q;
      cyc_n     = cyc_q;
      bit_n     = bit_q;
      byte_n    = byte_q;
      parity_n  = parity_q;
      data_oe_n = data_oe_q;
      done_n    = 1'b0;
      err_n     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            data_oe_n = 1'b0;
            if (tx.tx_valid) begin
               byte_n   = tx.tx_data;
               parity_n = odd_parity(tx.tx_data);
               cyc_n    = '0;
               state_n  = ST_INHIBIT;
            end
         end

         ST_INHIBIT: begin
            if (cyc_q == INH_LAST) begin
               cyc_n     = '0;
               data_oe_n = 1'b1;          // start bit
               state_n   = ST_RTS;
            end else begin
               cyc_n = cyc_q + CNT_ONE;
            end
         end

         ST_RTS: begin
            if (cyc_q == RTS_LAST) begin
               cyc_n   = '0;              // timeout counts from clock release
               bit_n   = '0;
               state_n = ST_SEND;
            end else begin
               cyc_n = cyc_q + CNT_ONE;
            end
         end

         ST_SEND: begin
            cyc_n = cyc_q + CNT_ONE;
            // Change data on the device falling edge; the device samples on
            // the following rising edge.
            if (clk_fall) begin
               if (bit_q < 4'd8) begin
                  data_oe_n = ~byte_q[bit_q[2:0]];
               end else if (bit_q == 4'd8) begin
                  data_oe_n = ~parity_q;
               end else begin
                  data_oe_n = 1'b0;       // stop bit: release data
                  state_n   = ST_ACK;
               end
               bit_n = bit_q + 4'd1;
            end
         end

         ST_ACK: begin
            cyc_n = cyc_q + CNT_ONE;
            if (clk_fall) begin
               if (!data_s) begin
                  state_n = ST_WAIT_IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = ST_IDLE;
               end
            end
         end

         ST_WAIT_IDLE: begin
            cyc_n = cyc_q + CNT_ONE;
            if (clk_s && data_s) begin
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end
         end

         default: begin
            data_oe_n = 1'b0;
            state_n   = ST_IDLE;
         end
      endcase

      // Timeout overrides whatever the frame states decided this cycle.
      if (in_frame && (cyc_q == TMO_LAST)) begin
         state_n   = ST_IDLE;
         data_oe_n = 1'b0;
         done_n    = 1'b0;
         err_n     = 1'b1;
         cyc_n     = '0;
      end
   end

   assign ps2_clk_oe  = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
   assign ps2_data_oe = data_oe_q;
   assign tx.tx_ready = (state_q == ST_IDLE);
   assign tx.tx_done  = done_q;
   assign tx.tx_err   = err_q;
   assign fsm_state   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx -- bench for ps2_host_tx with an open-drain bus and a
// behavioural PS/2 device that clocks frames and captures the sent bits.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH  = 40;
   localparam int RTS  = 6;
   localparam int TMO  = 2000;
   localparam int HALF = 15;     // device clock half period in system clocks

   localparam logic [1:0] RESP_DONE = 2'b01;
   localparam logic [1:0] RESP_ERR  = 2'b10;

   // Frames as {stop, parity, data[7:0], start}, parity worked out by hand.
   localparam logic [10:0] FRAME_ED = {1'b1, 1'b1, 8'hED, 1'b0}; // 6 ones
   localparam logic [10:0] FRAME_F4 = {1'b1, 1'b0, 8'hF4, 1'b0}; // 5 ones
   localparam logic [10:0] FRAME_00 = {1'b1, 1'b1, 8'h00, 1'b0}; // 0 ones
   localparam logic [10:0] FRAME_FF = {1'b1, 1'b1, 8'hFF, 1'b0}; // 8 ones
   localparam logic [10:0] FRAME_01 = {1'b1, 1'b0, 8'h01, 1'b0}; // 1 one

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT and bus ----------------
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   ps2_state_t fsm_state;
   wire        pad_clk  = ~(ps2_clk_oe | dev_clk_low);
   wire        pad_data = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .RTS_CYCLES     (RTS),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk         (clk),
      .rst         (rst_n),
      .tx          (tx_if.slave),
      .ps2_clk_i   (pad_clk),
      .ps2_data_i  (pad_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .fsm_state   (fsm_state)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] exp_frame_q[$];
   logic [1:0]  exp_resp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every done/err pulse must match the next expectation.
   always @(negedge clk) begin
      if (tx_if.tx_done || tx_if.tx_err) begin
         check("done_err_exclusive", {31'd0, tx_if.tx_done & tx_if.tx_err}, 32'd0);
         if (exp_resp_q.size() == 0)
            check("unexpected_pulse", {30'd0, tx_if.tx_err, tx_if.tx_done}, 32'd0);
         else
            check("response", {30'd0, tx_if.tx_err, tx_if.tx_done}, {30'd0, exp_resp_q.pop_front()});
      end
   end

   task automatic frame_seen(input logic [10:0] got);
      check("frame_expected", {31'd0, exp_frame_q.size() != 0}, 32'd1);
      if (exp_frame_q.size() != 0)
         check("frame_bits", {21'd0, got}, {21'd0, exp_frame_q.pop_front()});
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic [7:0] d);
      @(negedge clk);
      check("ready_before_req", {31'd0, tx_if.tx_ready}, 32'd1);
      tx_if.tx_data  = d;
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
   endtask

   // Device model: measures inhibit/RTS, clocks the frame, optionally acks.
   // abort_at > 0 stops after that many clock pulses without comparing.
   task automatic device_run(input logic ack_ok, input int abort_at);
      int          inh_n;
      int          rts_n;
      logic [10:0] got;
      got   = '0;
      inh_n = 0;
      rts_n = 0;
      check("inhibit_start", {31'd0, ps2_clk_oe}, 32'd1);
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && inh_n < INH + 100) begin
         inh_n++;
         @(negedge clk);
      end
      check("inhibit_len", inh_n, INH);
      while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && rts_n < RTS + 100) begin
         rts_n++;
         @(negedge clk);
      end
      check("rts_len", rts_n, RTS);
      check("clock_released", {31'd0, ps2_clk_oe}, 32'd0);
      got[0] = pad_data;
      repeat (HALF) @(negedge clk);
      for (int k = 1; k <= 10; k++) begin
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge clk);
         got[k] = pad_data;        // value seen at the rising edge
         dev_clk_low = 1'b0;
         if (k == abort_at) return;
         repeat (HALF) @(negedge clk);
      end
      if (ack_ok) dev_data_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
      frame_seen(got);
   endtask

   task automatic wait_resp();
      int t;
      t = 0;
      while (exp_resp_q.size() != 0 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("response_arrived", exp_resp_q.size(), 0);
      @(negedge clk);
      check("idle_ready", {31'd0, tx_if.tx_ready}, 32'd1);
      check("idle_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
   endtask

   task automatic run_frame(input logic [7:0] d, input logic [10:0] f, input logic ack_ok);
      exp_frame_q.push_back(f);
      exp_resp_q.push_back(ack_ok ? RESP_DONE : RESP_ERR);
      send_req(d);
      device_run(ack_ok, 0);
      wait_resp();
   endtask

   task automatic run_timeout(input logic [7:0] d);
      int t;
      int t0;
      exp_resp_q.push_back(RESP_ERR);
      send_req(d);
      t = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && t < INH + RTS + 50) begin
         @(negedge clk);
         t++;
      end
      t0 = cyc;
      t  = 0;
      while (tx_if.tx_err !== 1'b1 && t < TMO + 100) begin
         @(negedge clk);
         t++;
      end
      check("timeout_latency", cyc - t0, TMO);
      check("timeout_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      wait_resp();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int busy;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, tx_if.tx_ready}, 32'd1);
      check("rst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("rst_pulses", {30'd0, tx_if.tx_err, tx_if.tx_done}, 32'd0);
      check("rst_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
      rst_n = 1'b1;
      @(negedge clk);

      // Directed bytes, acked by the device.
      run_frame(8'hED, FRAME_ED, 1'b1);
      run_frame(8'hF4, FRAME_F4, 1'b1);
      run_frame(8'h00, FRAME_00, 1'b1);
      run_frame(8'hFF, FRAME_FF, 1'b1);

      // Device leaves data high at the 11th falling edge.
      run_frame(8'hED, FRAME_ED, 1'b0);

      // Device never clocks after release.
      run_timeout(8'h55);

      // Reset after the 4th data bit of 0x05 (bit 3 = 0, so data is driven).
      send_req(8'h05);
      device_run(1'b1, 4);
      check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      check("async_reset_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      run_frame(8'h01, FRAME_01, 1'b1);

      // Second request (0xAA) while a 0xED frame is in flight.
      exp_frame_q.push_back(FRAME_ED);
      exp_resp_q.push_back(RESP_DONE);
      send_req(8'hED);
      fork
         device_run(1'b1, 0);
         begin
            repeat (10) @(negedge clk);
            tx_if.tx_data  = 8'hAA;
            tx_if.tx_valid = 1'b1;
            repeat (250) @(negedge clk);
            tx_if.tx_valid = 1'b0;
         end
      join
      wait_resp();
      busy = 0;
      repeat (50) begin
         @(negedge clk);
         if (ps2_clk_oe) busy++;
      end
      check("no_queued_frame", busy, 0);

      // Device clock edges while idle are ignored.
      repeat (3) begin
         dev_clk_low = 1'b1;
         repeat (5) @(negedge clk);
         dev_clk_low = 1'b0;
         repeat (5) @(negedge clk);
      end
      check("idle_edges_state", {29'd0, fsm_state}, {29'd0, ST_IDLE});
      check("idle_edges_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

      repeat (10) @(negedge clk);
      check("resp_queue_empty", exp_resp_q.size(), 0);
      check("frame_queue_empty", exp_frame_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish by cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 10000, clk cycles PS/2 clock held low for request-to-send (100 us at 100 MHz).
REQ-002 SHALL have parameter RTS_CYCLES, default 20, clk cycles data held low together with clock before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 2000000, frame-abort limit counted from clock release (20 ms).
REQ-004 SHALL have ports:
  clk  input  1  system clock, 100 MHz, single clock domain.
  rst  input  1  reset, asynchronous, active-low.
  tx_valid  input  1  request to send tx_data; sampled only when tx_ready=1.
  tx_data  input  8  command byte, e.g. 0xED set-LEDs, 0xF4 enable.
  tx_ready  output  1  high only in IDLE.
  tx_done  output  1  one-cycle pulse: frame acknowledged, bus idle.
  tx_err  output  1  one-cycle pulse: missing ack or timeout.
  ps2_clk_i  input  1  PS2_CLK pad level, asynchronous.
  ps2_data_i  input  1  PS2_DATA pad level, asynchronous.
  ps2_clk_oe  output  1  1 = drive PS2_CLK low, 0 = release (open-drain; top level builds the tristate).
  ps2_data_oe  output  1  1 = drive PS2_DATA low, 0 = release.

Function
REQ-005 SHALL pass ps2_clk_i and ps2_data_i through 2-FF synchronizers; a device falling edge is synced clk previous 1, current 0.
REQ-006 SHALL implement states IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
REQ-007 IDLE: both oe=0, tx_ready=1; tx_valid=1 latches tx_data, computes odd parity (~^tx_data), goes to INHIBIT next cycle.
REQ-008 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-009 RTS: clk_oe=1, data_oe=1 (start bit) for RTS_CYCLES cycles, then clk_oe=0 with data_oe still 1, enter SEND with bit counter 0 and timeout counter cleared.
REQ-010 SEND: on each device falling edge, counter n: n=0..7 sets data_oe=~tx_data[n] (LSB first), n=8 sets data_oe=~parity, n=9 sets data_oe=0 (stop); counter increments; after n=9 go to ACK.
REQ-011 ACK: on next falling edge sample synced data; 0 -> WAIT_IDLE; 1 -> pulse tx_err, go to IDLE.
REQ-012 WAIT_IDLE: when synced clock and data both 1, pulse tx_done and go to IDLE.
REQ-013 Timeout counter runs in SEND, ACK, WAIT_IDLE; reaching TIMEOUT_CYCLES releases both lines, pulses tx_err, returns to IDLE in the same cycle.
REQ-014 tx_valid while tx_ready=0 SHALL be ignored and not queued; tx_data changes after acceptance SHALL not affect the frame.
REQ-015 tx_done and tx_err SHALL never assert in the same cycle; exactly one pulses per accepted request.
REQ-016 Device clock edges outside SEND/ACK SHALL be ignored.

Reset
REQ-017 rst low SHALL immediately (asynchronously) force IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_done=0, tx_err=0, all counters and synchronizers to 0/idle level (sync FFs reset to 1); tx_ready=1 after release.
REQ-018 Reset mid-frame SHALL abort the frame without a tx_done or tx_err pulse.

Structure
REQ-019 State encoding and the default parameter constants SHALL live in a shared package ps2_pkg used with the existing keyboard receive path.
REQ-020 One sub-module SHALL be natural: ps2_sync (2-FF synchronizer plus falling-edge detect), reusable by the receiver.
REQ-021 No other sub-modules; the datapath is one shift/bit counter, one cycle counter shared by INHIBIT/RTS/timeout, and the FSM.

Verification
REQ-022 Device model clocks 11 edges at 12.5 kHz and acks: tx_data=0xED -> clk_oe low 10000 cycles, lines sampled at rising edges give start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done one pulse.
REQ-023 tx_data=0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; tx_done pulse; tx_ready returns to 1.
REQ-024 Device leaves data high at the 11th falling edge -> tx_err one pulse, no tx_done, both oe=0.
REQ-025 Device never clocks after release -> tx_err exactly TIMEOUT_CYCLES cycles after clock release, lines released.
REQ-026 rst low after the 4th data bit -> both oe=0 asynchronously, no pulses; next 0x01 request sends parity 0 correctly.
REQ-027 Second tx_valid (0xAA) during a 0xED frame -> ignored; only 0xED appears on the bus, one tx_done.
